// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the memory BIST controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CMP,
    S_DONE
  } state_t;

  localparam int unsigned MARCH_ELEMS = 6;

  localparam logic [7:0] BG0 = 8'h00;
  localparam logic [7:0] BG1 = 8'hFF;

  // Per-element tables, bit i describes element Ei.
  localparam logic [MARCH_ELEMS-1:0] ELEM_DESC      = 6'b011000; // E3,E4 descend
  localparam logic [MARCH_ELEMS-1:0] ELEM_HAS_READ  = 6'b111110; // E1..E5
  localparam logic [MARCH_ELEMS-1:0] ELEM_RD_ONE    = 6'b010100; // E2,E4 read 1s
  localparam logic [MARCH_ELEMS-1:0] ELEM_HAS_WRITE = 6'b011111; // E0..E4
  localparam logic [MARCH_ELEMS-1:0] ELEM_WR_ONE    = 6'b001010; // E1,E3 write 1s

  function automatic logic elem_valid(input logic [2:0] e);
    return e < 3'(MARCH_ELEMS);
  endfunction

  function automatic logic elem_up(input logic [2:0] e);
    return elem_valid(e) ? !ELEM_DESC[e] : 1'b1;
  endfunction

  function automatic logic elem_has_read(input logic [2:0] e);
    return elem_valid(e) ? ELEM_HAS_READ[e] : 1'b0;
  endfunction

  function automatic logic elem_has_write(input logic [2:0] e);
    return elem_valid(e) ? ELEM_HAS_WRITE[e] : 1'b0;
  endfunction

  function automatic logic [7:0] elem_rd_val(input logic [2:0] e);
    return (elem_valid(e) && ELEM_RD_ONE[e]) ? BG1 : BG0;
  endfunction

  function automatic logic [7:0] elem_wr_val(input logic [2:0] e);
    return (elem_valid(e) && ELEM_WR_ONE[e]) ? BG1 : BG0;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; o_last flags the final address of the
// current sweep direction.
module mbist_addr_gen #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_step,
  input  logic              i_up,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;

  // Address register: load takes priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_step) begin
      r_addr <= i_up ? r_addr + ADDR_W'(1) : r_addr - ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_up ? (r_addr == '1) : (r_addr == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences the six elements over the SRAM,
// drives strobes and expected data, and keeps sticky failure status.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_din,
  output logic              sram_we,
  output logic              sram_re,
  output logic [7:0]        data_t,
  input  logic              cmp_eq,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_count
);

  state_t            r_state;
  logic [2:0]        r_elem;
  logic              r_we;
  logic              r_re;
  logic [7:0]        r_din;
  logic [7:0]        r_data_t;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic [7:0]        r_fail_count;

  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_start;
  logic              w_adv;
  logic              w_end;
  logic [2:0]        w_next_elem;
  state_t            w_adv_state;
  logic              w_step;
  logic              w_load;
  logic [ADDR_W-1:0] w_load_val;

  mbist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_step    (w_step),
    .i_up      (elem_up(r_elem)),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // Address-advance decisions: every WRITE ends an address visit, as does
  // the CMP of the read-only final element.
  always_comb begin
    w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
    w_adv       = (r_state == S_WRITE) ||
                  (r_state == S_CMP && !elem_has_write(r_elem));
    w_end       = w_last && (r_elem == 3'(MARCH_ELEMS - 1));
    w_next_elem = w_last ? r_elem + 3'd1 : r_elem;
    w_adv_state = w_end ? S_DONE :
                  (elem_has_read(w_next_elem) ? S_READ : S_WRITE);
    w_step      = w_adv && !w_last;
    w_load      = w_start || (w_adv && w_last && !w_end);
    w_load_val  = (w_start || elem_up(w_next_elem)) ? '0 : '1;
  end

  // Main FSM with registered strobes, data and status.
  // Address advance is applied after the per-state case so WRITE and the
  // final element's CMP share one exit path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_elem       <= '0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_din        <= '0;
      r_data_t     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_elem  <= '0;
      r_fail_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_WRITE;
            r_elem       <= '0;
            r_we         <= 1'b1;
            r_re         <= 1'b0;
            r_din        <= elem_wr_val(3'd0);
            r_data_t     <= elem_rd_val(3'd0);
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_elem  <= '0;
            r_fail_count <= '0;
          end
        end
        S_READ: begin
          r_state <= S_CMP;
          r_re    <= 1'b0;
        end
        S_CMP: begin
          if (!cmp_eq) begin
            r_fail <= 1'b1;
            if (r_fail_count != 8'hFF) begin
              r_fail_count <= r_fail_count + 8'd1;
            end
            if (!r_fail) begin
              r_fail_addr <= w_addr;
              r_fail_elem <= r_elem;
            end
          end
          if (elem_has_write(r_elem)) begin
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_din   <= elem_wr_val(r_elem);
          end
        end
        S_WRITE: begin
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_adv) begin
        if (!w_end) begin
          r_elem <= w_next_elem;
        end
        r_state  <= w_adv_state;
        r_we     <= (w_adv_state == S_WRITE);
        r_re     <= (w_adv_state == S_READ);
        r_din    <= elem_wr_val(w_next_elem);
        r_data_t <= w_end ? BG0 : elem_rd_val(w_next_elem);
        r_busy   <= !w_end;
        r_done   <= w_end;
      end
    end
  end

  assign sram_addr  = w_addr;
  assign sram_din   = r_din;
  assign sram_we    = r_we;
  assign sram_re    = r_re;
  assign data_t     = r_data_t;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;
  assign fail_addr  = r_fail_addr;
  assign fail_elem  = r_fail_elem;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: table-driven fault cases,
// randomized faults against a March C- reference model, reset/start corners,
// and a 64-word instance for failure-count saturation.
module tb_mbist_march_ctrl;

  localparam int AW  = 3;
  localparam int NW  = 1 << AW;
  localparam int AW6 = 6;
  localparam int NW6 = 1 << AW6;
  localparam int LIMIT = 15 * NW + 20;

  typedef logic [AW+8:0] ent_t;   // {is_write, addr, data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start6 = 1'b0;

  logic [AW-1:0] sram_addr, fail_addr;
  logic [7:0]    sram_din, data_t, fail_count, ramout;
  logic          sram_we, sram_re, cmp_eq, busy, done, fail;
  logic [2:0]    fail_elem;

  logic [AW6-1:0] sram_addr6, fail_addr6;
  logic [7:0]     sram_din6, data_t6, fail_count6;
  logic           sram_we6, sram_re6, cmp_eq6, busy6, done6, fail6;
  logic [2:0]     fail_elem6;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
    .sram_re(sram_re), .data_t(data_t), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_count(fail_count)
  );

  mbist_march_ctrl #(.ADDR_W(AW6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6),
    .sram_addr(sram_addr6), .sram_din(sram_din6), .sram_we(sram_we6),
    .sram_re(sram_re6), .data_t(data_t6), .cmp_eq(cmp_eq6),
    .busy(busy6), .done(done6), .fail(fail6), .fail_addr(fail_addr6),
    .fail_elem(fail_elem6), .fail_count(fail_count6)
  );

  // Single stuck-at cell fault, applied when the word is read.
  bit f_en;
  int f_addr, f_bit;
  bit f_val;

  function automatic logic [7:0] fault_read(input logic [7:0] d, input int a,
                                            input bit en, input int fa,
                                            input int fb, input bit fv);
    logic [7:0] r;
    r = d;
    if (en && a == fa) r[fb] = fv;
    return r;
  endfunction

  // SRAM model with one-cycle read latency.
  logic [7:0] mem [NW];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    if (sram_re) ramout <= fault_read(mem[sram_addr], int'(sram_addr),
                                      f_en, f_addr, f_bit, f_val);
  end
  assign cmp_eq  = (data_t == ramout);
  // Second instance: every word of its memory reads back 8'hA5.
  assign cmp_eq6 = (data_t6 == 8'hA5);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, exp);
    end
  endtask

  // March C- definition: direction (1 = descending), read value, write value
  // (-1 = no such operation in the element).
  int el_desc [6] = '{0, 0, 0, 1, 1, 0};
  int el_rd   [6] = '{-1, 0, 255, 0, 255, 0};
  int el_wr   [6] = '{0, 255, 0, 255, 0, -1};

  ent_t exp_q[$];
  ent_t obs_q[$];

  task automatic model_run(input bit en, input int fa, input int fb, input bit fv,
                           output int m_fail, output int m_addr,
                           output int m_elem, output int m_cnt);
    logic [7:0]    mm [NW];
    logic [7:0]    rv;
    logic [AW-1:0] av;
    int a;
    exp_q.delete();
    m_fail = 0; m_addr = 0; m_elem = 0; m_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < NW; k++) begin
        a  = (el_desc[e] != 0) ? NW - 1 - k : k;
        av = a[AW-1:0];
        if (el_rd[e] >= 0) begin
          exp_q.push_back({1'b0, av, 8'(el_rd[e])});
          rv = fault_read(mm[a], a, en, fa, fb, fv);
          if (int'(rv) != el_rd[e]) begin
            if (m_fail == 0) begin m_addr = a; m_elem = e; end
            m_fail = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
        if (el_wr[e] >= 0) begin
          mm[a] = 8'(el_wr[e]);
          exp_q.push_back({1'b1, av, 8'(el_wr[e])});
        end
      end
    end
  endtask

  int done_cyc, busy_cyc, n_wr, n_rd, viol, c1_fail, c1_cnt;

  task automatic check_zero(input string tag);
    check(tag, "strobes_flags", int'({sram_we, sram_re, busy, done, fail}), 0);
    check(tag, "din_data_t", int'({sram_din, data_t}), 0);
    check(tag, "addrs_elem", int'({sram_addr, fail_addr, fail_elem}), 0);
    check(tag, "fail_count", int'(fail_count), 0);
  endtask

  // Start a test at edge 0 and observe cycles 1.. until done (bounded).
  // pulse_at: cycle in which start is raised again; rst_at: cycle in which
  // rst_n is pulled low (run abandoned after checking outputs).
  task automatic run_test(input string tag, input int pulse_at, input int rst_at);
    obs_q.delete();
    done_cyc = -1; busy_cyc = 0; n_wr = 0; n_rd = 0; viol = 0;
    c1_fail = -1; c1_cnt = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async_rst"});
        break;
      end
      if (c == 1) begin c1_fail = int'(fail); c1_cnt = int'(fail_count); end
      if (sram_we && sram_re) viol++;
      if (busy && done) viol++;
      if (sram_we) begin n_wr++; obs_q.push_back({1'b1, sram_addr, sram_din}); end
      if (sram_re) begin n_rd++; obs_q.push_back({1'b0, sram_addr, data_t}); end
      if (busy) busy_cyc++;
      if (done) begin done_cyc = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input bit en, input int fa, input int fb, input bit fv);
    int mf, ma, me, mc, mism;
    model_run(en, fa, fb, fv, mf, ma, me, mc);
    check(tag, "done_cycle", done_cyc, 15 * NW + 1);
    check(tag, "busy_cycles", busy_cyc, 15 * NW);
    check(tag, "overlap", viol, 0);
    check(tag, "writes", n_wr, 5 * NW);
    check(tag, "reads", n_rd, 5 * NW);
    check(tag, "fail", int'(fail), mf);
    check(tag, "fail_addr", int'(fail_addr), ma);
    check(tag, "fail_elem", int'(fail_elem), me);
    check(tag, "fail_count", int'(fail_count), mc);
    mism = (exp_q.size() == obs_q.size()) ? 0 : 1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (exp_q[i] != obs_q[i]) mism++;
    check(tag, "op_trace_mismatches", mism, 0);
  endtask

  typedef struct {
    bit en; int fa; int fb; bit fv;
    int x_fail; int x_addr; int x_elem; int x_cnt;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{en:0, fa:0, fb:0, fv:0, x_fail:0, x_addr:0, x_elem:0, x_cnt:0};
    vt[1] = '{en:1, fa:5, fb:0, fv:1, x_fail:1, x_addr:5, x_elem:1, x_cnt:3};
    vt[2] = '{en:1, fa:2, fb:7, fv:0, x_fail:1, x_addr:2, x_elem:2, x_cnt:2};
    vt[3] = '{en:1, fa:0, fb:3, fv:1, x_fail:1, x_addr:0, x_elem:1, x_cnt:3};
    vt[4] = '{en:1, fa:7, fb:0, fv:0, x_fail:1, x_addr:7, x_elem:2, x_cnt:2};

    f_en = 0; f_addr = 0; f_bit = 0; f_val = 0;
    #22;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("idle");

    // Table-driven fault cases with hand-derived status.
    for (int i = 0; i < 5; i++) begin
      f_en = vt[i].en; f_addr = vt[i].fa; f_bit = vt[i].fb; f_val = vt[i].fv;
      run_test("vec", 0, 0);
      check("vec", "tbl_fail", int'(fail), vt[i].x_fail);
      check("vec", "tbl_fail_addr", int'(fail_addr), vt[i].x_addr);
      check("vec", "tbl_fail_elem", int'(fail_elem), vt[i].x_elem);
      check("vec", "tbl_fail_count", int'(fail_count), vt[i].x_cnt);
      verify("vec", f_en, f_addr, f_bit, f_val);
      repeat (3) @(negedge clk);
      check("vec", "done_hold", int'({done, busy}), 2);
    end

    // Start in DONE after a failing run: status cleared, clean rerun.
    f_en = 0;
    run_test("rerun", 0, 0);
    check("rerun", "c1_fail_cleared", c1_fail, 0);
    check("rerun", "c1_count_cleared", c1_cnt, 0);
    verify("rerun", 0, 0, 0, 0);

    // Async reset mid-E2 (E2 spans cycles 33..56 for N=8), then a clean run.
    f_en = 1; f_addr = 5; f_bit = 0; f_val = 1;
    run_test("midrst", 0, 40);
    @(negedge clk);
    check_zero("held_rst");
    rst_n = 1'b1;
    f_en = 0;
    run_test("after_rst", 0, 0);
    verify("after_rst", 0, 0, 0, 0);

    // Start pulsed while busy must not disturb the sequence.
    f_en = 1; f_addr = 3; f_bit = 4; f_val = 1;
    run_test("busy_start", 60, 0);
    verify("busy_start", f_en, f_addr, f_bit, f_val);

    // Randomized single stuck-at faults and stray start pulses.
    for (int r = 0; r < 8; r++) begin
      f_en   = ($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, NW - 1);
      f_bit  = $urandom_range(0, 7);
      f_val  = $urandom_range(0, 1);
      run_test("rand", ($urandom_range(0, 1) != 0) ? $urandom_range(2, 15 * NW) : 0, 0);
      verify("rand", f_en, f_addr, f_bit, f_val);
    end

    // 64-word instance: every read miscompares, count saturates.
    @(negedge clk);
    start6 = 1'b1;
    @(posedge clk);
    #1 start6 = 1'b0;
    for (int c = 1; c <= 15 * NW6 + 20; c++) begin
      @(negedge clk);
      if (done6) break;
    end
    check("sat", "done", int'(done6), 1);
    check("sat", "fail", int'(fail6), 1);
    check("sat", "fail_count", int'(fail_count6), 255);
    check("sat", "fail_addr", int'(fail_addr6), 0);
    check("sat", "fail_elem", int'(fail_elem6), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory BIST controller for one 8-bit-wide SRAM. On `start` it sequences the six March C- elements over every address, drives SRAM address, data and strobes, and presents the expected word to the magnitude comparator. It samples the comparator's `eq` result, records sticky pass/fail status, the first failing address/element, and a saturating failure count. It sits between the BIST top-level (start/done/status) and the SRAM + comparator datapath.

## Interface
- `ADDR_W`, 6: SRAM address width; N = 2^ADDR_W words.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `start`  in  1  begin test; sampled only in IDLE or DONE.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_din`  out  8  SRAM write data.
- `sram_we`  out  1  SRAM write strobe, one cycle per write.
- `sram_re`  out  1  SRAM read strobe; data valid on `ramout` next cycle.
- `data_t`  out  8  expected word to comparator.
- `cmp_eq`  in  1  comparator `eq` (data_t == ramout).
- `busy`  out  1  test in progress.
- `done`  out  1  test complete; held until next start.
- `fail`  out  1  sticky, at least one miscompare.
- `fail_addr`  out  ADDR_W  address of first miscompare.
- `fail_elem`  out  3  March element (0..5) of first miscompare.
- `fail_count`  out  8  miscompare count, saturates at 8'hFF.

## Operation
- March C- elements: E0 ⇕(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇕(r0). w0/r0 = 8'h00, w1/r1 = 8'hFF. ⇕ elements run ascending.
- States: IDLE, WRITE, READ, CMP, DONE.
- IDLE/DONE + start: clear fail, fail_addr, fail_elem, fail_count; elem=0, addr=0; go WRITE.
- WRITE: `sram_we`=1, `sram_din`=element write value. If element has a preceding read (E1–E4), advance address afterwards; E0 advances address in WRITE.
- READ: `sram_re`=1; next CMP.
- CMP: `data_t`=element read value; sample `cmp_eq`. On miscompare: fail←1, fail_count+1 (saturating), capture addr/elem only if fail was 0. E1–E4 → WRITE (same address); E5 → advance address.
- Address advance: ascending ends at N-1, descending at 0. At last address move to next element, loading addr 0 (ascending) or N-1 (descending). After E5 at N-1 → DONE.
- Element first state: E0 WRITE, E1–E5 READ.
- Test continues to completion after failures.
- `start` while busy is ignored.
- `data_t` holds the current element's read value in every state; 8'h00 in IDLE/DONE.

## Timing
- Reset (async, any state incl. mid-test): state IDLE; all outputs 0; counters 0. Exit sync on first rising edge with rst_n high.
- Strobes and addr are registered; `sram_addr` stable for the cycle its strobe is high.
- Read latency 1: READ at cycle k, `cmp_eq` valid and sampled in cycle k+1 (CMP).
- Cycles/address: E0 1, E1–E4 3, E5 2; total 15·N cycles busy.
- Edge 0 samples start; busy high cycles 1..15·N; done high from cycle 15·N+1; busy and done never both high.
- Never both `sram_we` and `sram_re` high.
- Miscompare in the last CMP still updates status before done rises.

## Structure
- Package `mbist_pkg`: state enum, `MARCH_ELEMS`=6, per-element constant tables (direction, has_read, read value, has_write, write value), `BG0`=8'h00, `BG1`=8'hFF.
- Sub-module `mbist_addr_gen`: loadable up/down address counter with `last` flag; controller owns FSM and status registers.
- Comparator instantiated at the BIST top, not inside this block.

## Test plan
- ADDR_W=3, fault-free SRAM model: start at edge 0 → done at cycle 121, fail=0, fail_count=0, exactly 40 writes and 40 reads observed.
- Bit 0 of address 5 stuck-at-1 → fail=1, fail_addr=5, fail_elem=1, fail_count=3 (E1, E3, E5).
- Address order check: E3/E4 reads issued 7,6,…,0; E1/E2 reads 0..7; each E1 write at same address as preceding read.
- All words stuck at 8'hA5 with ADDR_W=6 → fail_count saturates at 8'hFF, fail_addr=0, fail_elem=1.
- rst_n low mid-E2 → all outputs 0 immediately; new start runs full clean test, done after 15·N cycles.
- start pulsed while busy → ignored, timing unchanged; start in DONE → status cleared, test reruns.
